mem_read_seq: RTL and testbench
===============================

MEM_READ_SEQ -- requirements
Module: mem_read_seq

Interface
REQ-001 SHALL have parameter N, default 3: number of BRAM banks and systolic array dimension.
REQ-002 SHALL have parameter M, default 6: square matrix dimension, an integer multiple of N.
REQ-003 SHALL derive localparam AW = $clog2((M*M)/N), the per-bank address width; minimum 1.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock.
REQ-005 SHALL have port rst, input, width 1: synchronous active-high reset.
REQ-006 SHALL have port start, input, width 1: one-cycle request to begin a sweep; sampled only in IDLE.
REQ-007 SHALL have port stall, input, width 1: freezes address generation for the current cycle.
REQ-008 SHALL have port rd_addr_bram, output, width AW x N (unpacked [N-1:0]): per-bank read address.
REQ-009 SHALL have port rd_en_bram, output, width N: per-bank read enable.
REQ-010 SHALL have port busy, output, width 1: high in RUN and DRAIN.
REQ-011 SHALL have port done, output, width 1: one-cycle pulse at sweep completion.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-013 SHALL go from IDLE to RUN on start; start in RUN or DRAIN SHALL be ignored.
REQ-014 SHALL, in RUN, keep row counter r (0..M-1, inner) and column counter c (0..M/N-1, outer); both zero on entry.
REQ-015 SHALL register the bank-0 address as c*M + r with width AW, giving M*M/N reads per sweep.
REQ-016 SHALL assert rd_en_bram[0] with address 0 in the cycle after start is accepted.
REQ-017 SHALL give bank x (x>=1) exactly the address and enable of bank x-1 delayed one cycle: a skewed wavefront.
REQ-018 SHALL, when stall=1 in RUN, not advance r or c and drive a bubble (rd_en 0) into bank 0 for that cycle; the skew chain SHALL keep shifting.
REQ-019 SHALL, on the final read (r=M-1, c=M/N-1, stall=0), wrap both counters to 0 and enter DRAIN; with N=1 it SHALL go directly to IDLE.
REQ-020 SHALL hold DRAIN for N-1 cycles, then enter IDLE and pulse done for exactly that first IDLE cycle.
REQ-021 SHALL accept start in the same cycle done is high.
REQ-022 SHALL ignore stall in DRAIN and IDLE.
REQ-023 SHALL hold every rd_addr_bram entry at 0 whenever the matching rd_en_bram bit is 0 in IDLE.

Reset
REQ-024 SHALL, on rst, set state IDLE, r=c=0, all rd_en_bram=0, all rd_addr_bram=0, busy=0 and done=0.
REQ-025 SHALL, on rst during RUN or DRAIN, abort immediately with all skew stages cleared and no done pulse.
REQ-026 SHALL give rst priority over start and stall.

Configuration
REQ-027 SHALL, when macro MEM_READ_SEQ_TRANSPOSE_EN is defined, add input transpose (width 1), latched at start acceptance.
REQ-028 SHALL, with latched transpose=1, generate bank-0 address r*(M/N) + c; transpose=0 SHALL keep REQ-015.
REQ-029 SHALL, without the macro, have no transpose port and no transpose register, with behaviour exactly REQ-015.

Structure
REQ-030 SHALL place the FSM state enum typedef in shared package mem_read_pkg.
REQ-031 SHALL place in mem_read_pkg a function computing the sweep length (M*M)/N.
REQ-032 SHALL implement the per-bank delay line as sub-module skew_pipe (parameters N, AW), with its own synchronous reset.
REQ-033 SHALL raise an elaboration error if M mod N != 0 or N < 1.

Verification
REQ-034 SHALL cover the basic sweep (N=3, M=6): start at cycle 0 -> bank0 addresses 0..5,6..11 on cycles 1..12; bank2 the same on cycles 3..14; busy cycles 1..14; done only at cycle 15.
REQ-035 SHALL cover stall: stall high at cycles 4-5 -> bank0 holds at address 3 with rd_en 0 on those cycles, bank1 bubbles on cycles 5-6, and done moves to cycle 17.
REQ-036 SHALL cover reset mid-sweep: rst at cycle 7 -> from cycle 8 all rd_en 0, all addresses 0, busy 0, and no done.
REQ-037 SHALL cover back-to-back sweeps: start asserted with done at cycle 15 -> bank0 address 0 at cycle 16; start pulses during busy have no effect.
REQ-038 SHALL cover transpose (macro on, transpose=1): bank0 sequence 0,2,4,6,8,10,1,3,... and final address 11.
REQ-039 SHALL cover N=1, M=4: 16 reads on cycles 1..16, no DRAIN, done at cycle 17.

Source files
------------

// File: rtl/mem_read_pkg.sv
// Shared types and helpers for the skewed BRAM read sequencer.
package mem_read_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int sweep_len(input int m, input int n);
    return (m * m) / n;
  endfunction

endpackage

// File: rtl/mem_read_seq_skew_pipe.sv
// Per-bank delay line: bank x sees bank x-1's address/enable one cycle later.
module skew_pipe #(
  parameter int N  = 3,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  input  logic [AW-1:0] addr_in,
  output logic [N-1:0]  en_out,
  output logic [AW-1:0] addr_out [N-1:0]
);

  generate
    if (N > 1) begin : g_pipe
      logic [N-2:0]  vld_pipe;
      logic [AW-1:0] addr_pipe [N-2:0];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe <= '0;
          for (int i = 0; i < N-1; i++) addr_pipe[i] <= '0;
        end else begin
          vld_pipe[0]  <= en_in;
          addr_pipe[0] <= addr_in;
          for (int i = 1; i < N-1; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
          end
        end
      end

      always_comb begin
        en_out[0]   = en_in;
        addr_out[0] = addr_in;
        for (int i = 1; i < N; i++) begin
          en_out[i]   = vld_pipe[i-1];
          addr_out[i] = addr_pipe[i-1];
        end
      end
    end else begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk | rst;
      assign en_out[0]      = en_in;
      assign addr_out[0]    = addr_in;
    end
  endgenerate

endmodule

// File: rtl/mem_read_seq.sv
// Skewed read-address sequencer feeding N BRAM banks of an NxN systolic array.
// Optional MEM_READ_SEQ_TRANSPOSE_EN adds a start-latched transposed sweep order.
module mem_read_seq
  import mem_read_pkg::*;
#(
  parameter  int N  = 3,
  parameter  int M  = 6,
  localparam int SL = (N < 1) ? 1 : sweep_len(M, N),
  localparam int AW = (SL > 1) ? $clog2(SL) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
`ifdef MEM_READ_SEQ_TRANSPOSE_EN
  input  logic          transpose,
`endif
  output logic [AW-1:0] rd_addr_bram [N-1:0],
  output logic [N-1:0]  rd_en_bram,
  output logic          busy,
  output logic          done
);

  localparam int CN    = (N < 1) ? 1 : M / N;
  localparam int RW    = (M > 1) ? $clog2(M) : 1;
  localparam int CW    = (CN > 1) ? $clog2(CN) : 1;
  localparam int DW    = (N > 1) ? $clog2(N) : 1;
  localparam int DLAST = (N > 1) ? N - 2 : 0;

  generate
    if (N < 1) begin : g_bad_n
      $error("mem_read_seq: N must be >= 1");
    end else if ((M % N) != 0) begin : g_bad_m
      $error("mem_read_seq: M must be a multiple of N");
    end
  endgenerate

  state_t        state, state_nx;
  logic [RW-1:0] r, r_nx;
  logic [CW-1:0] c, c_nx;
  logic [DW-1:0] dcnt;
  logic [AW-1:0] addr_q, addr_nx;
  logic          last, en0, done_q;
`ifdef MEM_READ_SEQ_TRANSPOSE_EN
  logic          tr_q;
`endif

  // r is the inner (row) index, c the outer (column block) index
  always_comb begin
    r_nx = r + RW'(1);
    c_nx = c;
    last = 1'b0;
    if (r == RW'(M-1)) begin
      r_nx = '0;
      c_nx = c + CW'(1);
      last = (c == CW'(CN-1));
    end
  end

  always_comb begin
    addr_nx = AW'(c_nx) * AW'(M) + AW'(r_nx);
`ifdef MEM_READ_SEQ_TRANSPOSE_EN
    if (tr_q) addr_nx = AW'(r_nx) * AW'(CN) + AW'(c_nx);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (!stall && last) state_nx = (N > 1) ? DRAIN : IDLE;
      DRAIN:   if (dcnt == DW'(DLAST)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // bank-0 enable is a bubble whenever stall is high in RUN
  always_comb begin
    busy = (state != IDLE);
    en0  = (state == RUN) && !stall;
    done = done_q;
  end

  // addr_q always holds the address of the current (r, c)
  always_ff @(posedge clk) begin
    if (rst) begin
      r      <= '0;
      c      <= '0;
      dcnt   <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
`ifdef MEM_READ_SEQ_TRANSPOSE_EN
      tr_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          r      <= '0;
          c      <= '0;
          dcnt   <= '0;
          addr_q <= '0;
`ifdef MEM_READ_SEQ_TRANSPOSE_EN
          tr_q   <= transpose;
`endif
        end
        RUN: if (!stall) begin
          if (last) begin
            r      <= '0;
            c      <= '0;
            addr_q <= '0;
            dcnt   <= '0;
            if (N == 1) done_q <= 1'b1;
          end else begin
            r      <= r_nx;
            c      <= c_nx;
            addr_q <= addr_nx;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (dcnt == DW'(DLAST)) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  skew_pipe #(.N(N), .AW(AW)) u_skew (
    .clk      (clk),
    .rst      (rst),
    .en_in    (en0),
    .addr_in  (addr_q),
    .en_out   (rd_en_bram),
    .addr_out (rd_addr_bram)
  );

endmodule

// File: tb/tb_mem_read_seq.sv
// Directed bench for mem_read_seq: N=3/M=6 instance plus an N=1/M=4 instance on shared stimulus.
module tb_mem_read_seq;

  logic       clk, rst, start, stall;
`ifdef MEM_READ_SEQ_TRANSPOSE_EN
  logic       transpose;
`endif
  logic [3:0] a3 [2:0];
  logic [2:0] en3;
  logic       busy3, done3;
  logic [3:0] a1 [0:0];
  logic [0:0] en1;
  logic       busy1, done1;

  int tests = 0;
  int fails = 0;

  mem_read_seq #(.N(3), .M(6)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
`ifdef MEM_READ_SEQ_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .rd_addr_bram(a3), .rd_en_bram(en3), .busy(busy3), .done(done3)
  );

  mem_read_seq #(.N(1), .M(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
`ifdef MEM_READ_SEQ_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .rd_addr_bram(a1), .rd_en_bram(en1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // per-cycle history, index = cycle number within the current scenario
  logic [2:0] h_en   [64];
  int         h_a0   [64];
  int         h_a1   [64];
  int         h_a2   [64];
  logic       h_busy [64];
  logic       h_done [64];
  logic       n_en   [64];
  int         n_a    [64];
  logic       n_busy [64];
  logic       n_done [64];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int k, input logic st, input logic sl, input logic rs);
    start = st;
    stall = sl;
    rst   = rs;
    @(negedge clk);
    h_en[k]   = en3;
    h_a0[k]   = int'(a3[0]);
    h_a1[k]   = int'(a3[1]);
    h_a2[k]   = int'(a3[2]);
    h_busy[k] = busy3;
    h_done[k] = done3;
    n_en[k]   = en1[0];
    n_a[k]    = int'(a1[0]);
    n_busy[k] = busy1;
    n_done[k] = done1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
`ifdef MEM_READ_SEQ_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       st;
    logic       sl;
    logic [2:0] en;
    int         a0, a1, a2;
    logic       busy, done;
  } vec_t;

  vec_t tv [17];

  initial begin
    int bad;

    // basic sweep with ignored start (RUN, DRAIN) and ignored stall (DRAIN, IDLE)
    tv[0]  = '{1'b1, 1'b0, 3'b000,  0,  0,  0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 3'b001,  0,  0,  0, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 3'b011,  1,  0,  0, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 3'b111,  2,  1,  0, 1'b1, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 3'b111,  3,  2,  1, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 3'b111,  4,  3,  2, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 3'b111,  5,  4,  3, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 3'b111,  6,  5,  4, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 3'b111,  7,  6,  5, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 3'b111,  8,  7,  6, 1'b1, 1'b0};
    tv[10] = '{1'b0, 1'b0, 3'b111,  9,  8,  7, 1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b0, 3'b111, 10,  9,  8, 1'b1, 1'b0};
    tv[12] = '{1'b0, 1'b0, 3'b111, 11, 10,  9, 1'b1, 1'b0};
    tv[13] = '{1'b0, 1'b1, 3'b110,  0, 11, 10, 1'b1, 1'b0};
    tv[14] = '{1'b1, 1'b0, 3'b100,  0,  0, 11, 1'b1, 1'b0};
    tv[15] = '{1'b0, 1'b1, 3'b000,  0,  0,  0, 1'b0, 1'b1};
    tv[16] = '{1'b0, 1'b0, 3'b000,  0,  0,  0, 1'b0, 1'b0};

    do_reset();
    for (int k = 0; k < 17; k++) begin
      cyc(k, tv[k].st, tv[k].sl, 1'b0);
      tests++;
      if (h_en[k] !== tv[k].en || h_a0[k] != tv[k].a0 || h_a1[k] != tv[k].a1 ||
          h_a2[k] != tv[k].a2 || h_busy[k] !== tv[k].busy || h_done[k] !== tv[k].done) begin
        fails++;
        $display("FAIL basic c%0d: got en=%b a=%0d/%0d/%0d busy=%b done=%b, expected en=%b a=%0d/%0d/%0d busy=%b done=%b",
                 k, h_en[k], h_a0[k], h_a1[k], h_a2[k], h_busy[k], h_done[k],
                 tv[k].en, tv[k].a0, tv[k].a1, tv[k].a2, tv[k].busy, tv[k].done);
      end
    end

    // stall at cycles 4-5
    do_reset();
    for (int k = 0; k < 19; k++) cyc(k, k == 0, (k == 4 || k == 5), 1'b0);
    chk("stall c4 en0", int'(h_en[4][0]), 0);
    chk("stall c4 a0",  h_a0[4], 3);
    chk("stall c5 en0", int'(h_en[5][0]), 0);
    chk("stall c5 a0",  h_a0[5], 3);
    chk("stall c6 en0", int'(h_en[6][0]), 1);
    chk("stall c6 a0",  h_a0[6], 3);
    chk("stall c5 en1", int'(h_en[5][1]), 0);
    chk("stall c6 en1", int'(h_en[6][1]), 0);
    chk("stall c7 en1", int'(h_en[7][1]), 1);
    chk("stall c7 a1",  h_a1[7], 3);
    chk("stall c12 a0", h_a0[12], 9);
    chk("stall c16 busy", int'(h_busy[16]), 1);
    chk("stall c16 done", int'(h_done[16]), 0);
    chk("stall c17 done", int'(h_done[17]), 1);
    chk("stall c17 busy", int'(h_busy[17]), 0);

    // reset mid-sweep at cycle 7
    do_reset();
    for (int k = 0; k < 21; k++) cyc(k, k == 0, 1'b0, k == 7);
    chk("rst c6 busy", int'(h_busy[6]), 1);
    chk("rst c8 en", int'(h_en[8]), 0);
    bad = 0;
    for (int k = 8; k < 21; k++)
      if (h_en[k] != 3'b000 || h_a0[k] != 0 || h_a1[k] != 0 || h_a2[k] != 0 ||
          h_busy[k] || h_done[k] || n_en[k] || n_a[k] != 0 || n_busy[k] || n_done[k]) bad++;
    chk("rst quiet cycles", bad, 0);

    // reset has priority over start and stall
    cyc(0, 1'b1, 1'b1, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b0);
    chk("rst prio busy", int'(h_busy[1]), 0);
    chk("rst prio en", int'(h_en[1]), 0);

    // back-to-back: start at 0, ignored at 3 and 13, accepted with done at 15
    do_reset();
    for (int k = 0; k < 32; k++) cyc(k, (k == 0 || k == 3 || k == 13 || k == 15), 1'b0, 1'b0);
    chk("b2b c4 a0", h_a0[4], 3);
    chk("b2b c15 done", int'(h_done[15]), 1);
    chk("b2b c16 en0", int'(h_en[16][0]), 1);
    chk("b2b c16 a0", h_a0[16], 0);
    chk("b2b c16 busy", int'(h_busy[16]), 1);
    chk("b2b c17 a0", h_a0[17], 1);
    bad = 0;
    for (int k = 16; k < 30; k++) if (h_done[k]) bad++;
    chk("b2b no early done", bad, 0);
    chk("b2b c30 done", int'(h_done[30]), 1);

    // N=1, M=4: 16 reads, no drain
    do_reset();
    for (int k = 0; k < 19; k++) cyc(k, k == 0, 1'b0, 1'b0);
    bad = 0;
    for (int k = 1; k < 17; k++)
      if (!n_en[k] || n_a[k] != k - 1 || !n_busy[k] || n_done[k]) bad++;
    chk("n1 reads", bad, 0);
    chk("n1 c16 a", n_a[16], 15);
    chk("n1 c17 en", int'(n_en[17]), 0);
    chk("n1 c17 busy", int'(n_busy[17]), 0);
    chk("n1 c17 done", int'(n_done[17]), 1);
    chk("n1 c18 done", int'(n_done[18]), 0);

`ifdef MEM_READ_SEQ_TRANSPOSE_EN
    // transposed order, transpose dropped after acceptance
    do_reset();
    transpose = 1'b1;
    cyc(0, 1'b1, 1'b0, 1'b0);
    transpose = 1'b0;
    for (int k = 1; k < 16; k++) cyc(k, 1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int k = 1; k < 13; k++)
      if (h_a0[k] != ((k - 1) % 6) * 2 + (k - 1) / 6) bad++;
    chk("tr sequence", bad, 0);
    chk("tr c2 a0", h_a0[2], 2);
    chk("tr c12 a0", h_a0[12], 11);
    chk("tr c15 done", int'(h_done[15]), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
